// File: rtl/phold_event_queue.sv
`timescale 1ns/1ps
// phold_event_queue
//   Event queue and dispatcher for a PHOLD-style simulation core. Holds up to
//   2^NQB pending events {time, LP id}. It hands the earliest one to the core,
//   waits for the core's done/ready handshake and queues the event the core
//   produces. It also accepts externally injected events.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid               core ready level (high = idle, result valid)
//   in_time, in_target     event produced by the core
//   inj_valid/time/id      external injection request
//   inj_ready              injection accepted when inj_valid && inj_ready
//   event_valid            one-cycle dispatch strobe to the core
//   event_id, event_time   dispatched event, held until the next dispatch
//   global_time            registered GVT
//   random_out             LFSR word, advanced once per dispatch
//   count                  number of valid queue entries
//   done                   queue drained with the FSM idle
//   overflow               sticky: a core event was dropped on a full queue
module phold_event_queue #(
  parameter int          NIDB     = 3,
  parameter int          NQB      = 4,
  parameter int          NRB      = 8,
  parameter logic [15:0] END_TIME = 16'd1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [15:0]     in_time,
  input  logic [NIDB-1:0] in_target,
  input  logic            inj_valid,
  input  logic [15:0]     inj_time,
  input  logic [NIDB-1:0] inj_id,
  output logic            inj_ready,
  output logic            event_valid,
  output logic [NIDB-1:0] event_id,
  output logic [15:0]     event_time,
  output logic [15:0]     global_time,
  output logic [NRB-1:0]  random_out,
  output logic [NQB:0]    count,
  output logic            done,
  output logic            overflow
);

  localparam int DEPTH = 1 << NQB;
  localparam int NLP   = 1 << NIDB;
  localparam logic [NQB:0] FULL_COUNT = (NQB+1)'(DEPTH);
  localparam logic [NQB:0] SEED_COUNT = (NQB+1)'(NLP);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t r_state, w_next;

  logic [DEPTH-1:0] r_valid;
  logic [15:0]      r_time [DEPTH];
  logic [NIDB-1:0]  r_id   [DEPTH];
  logic [NQB:0]     r_count;

  logic [NIDB-1:0]  r_event_id;
  logic [15:0]      r_event_time;
  logic [15:0]      r_global_time;
  logic [NRB-1:0]   r_lfsr;
  logic             r_done;
  logic             r_overflow;

  logic             w_min_found;
  logic [NQB-1:0]   w_min_idx;
  logic [15:0]      w_min_time;
  logic [NQB-1:0]   w_free_idx;
  logic             w_full;
  logic             w_dispatch;
  logic             w_core_req;
  logic             w_core_ins;
  logic             w_core_drop;
  logic             w_inj_rdy;
  logic             w_inj_ins;
  logic             w_ins;
  logic [15:0]      w_ins_time;
  logic [NIDB-1:0]  w_ins_id;
  logic [15:0]      w_gvt;
  logic [NRB-1:0]   w_lfsr_next;

  // Earliest valid entry; strict '<' keeps the lowest index on ties.
  always_comb begin
    w_min_found = 1'b0;
    w_min_idx   = '0;
    w_min_time  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (!w_min_found || r_time[i] < w_min_time)) begin
        w_min_found = 1'b1;
        w_min_idx   = i[NQB-1:0];
        w_min_time  = r_time[i];
      end
    end
  end

  // Lowest-index free slot (meaningful only when not full).
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = i[NQB-1:0];
    end
  end

  assign w_full      = (r_count == FULL_COUNT);
  assign w_dispatch  = (r_state == S_IDLE) && w_min_found;
  assign w_core_req  = (r_state == S_WAIT_DONE) && in_valid && (in_time < END_TIME);
  assign w_core_ins  = w_core_req && !w_full;
  assign w_core_drop = w_core_req && w_full;
  // A core result in the capture cycle blocks injection even if it is dropped.
  assign w_inj_rdy   = !rst && !w_full && !w_core_req;
  assign w_inj_ins   = inj_valid && w_inj_rdy;
  assign w_ins       = w_core_ins || w_inj_ins;
  assign w_ins_time  = w_core_ins ? in_time   : inj_time;
  assign w_ins_id    = w_core_ins ? in_target : inj_id;

  assign w_lfsr_next = {r_lfsr[NRB-2:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // GVT: queue minimum, also bounded by the in-flight event outside IDLE.
  always_comb begin
    w_gvt = r_global_time;
    if (r_state != S_IDLE) begin
      w_gvt = (w_min_found && (w_min_time < r_event_time)) ? w_min_time : r_event_time;
    end else if (w_min_found) begin
      w_gvt = w_min_time;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_min_found) w_next = S_SEND;
      S_SEND:      w_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (!in_valid) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (in_valid) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    event_valid = (r_state == S_SEND);
    inj_ready   = w_inj_rdy;
  end

  // Queue storage. Removal and insertion never hit the same slot: one is
  // valid, the other free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= (i < NLP);
        r_time[i]  <= '0;
        r_id[i]    <= i[NIDB-1:0];
      end
      r_count <= SEED_COUNT;
    end else begin
      if (w_dispatch) r_valid[w_min_idx] <= 1'b0;
      if (w_ins) begin
        r_valid[w_free_idx] <= 1'b1;
        r_time[w_free_idx]  <= w_ins_time;
        r_id[w_free_idx]    <= w_ins_id;
      end
      r_count <= r_count + (NQB+1)'(w_ins) - (NQB+1)'(w_dispatch);
    end
  end

  // Dispatch latch, LFSR, GVT and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_event_id    <= '0;
      r_event_time  <= '0;
      r_global_time <= '0;
      r_lfsr        <= NRB'(8'hA5);
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_dispatch) begin
        r_event_id   <= r_id[w_min_idx];
        r_event_time <= w_min_time;
        r_lfsr       <= w_lfsr_next;
      end
      r_global_time <= w_gvt;
      if ((r_state == S_IDLE) && (r_count == '0) && !inj_valid) r_done <= 1'b1;
      else if (w_ins)                                            r_done <= 1'b0;
      if (w_core_drop) r_overflow <= 1'b1;
    end
  end

  assign event_id    = r_event_id;
  assign event_time  = r_event_time;
  assign global_time = r_global_time;
  assign random_out  = r_lfsr;
  assign count       = r_count;
  assign done        = r_done;
  assign overflow    = r_overflow;

endmodule

// File: doc/phold_event_queue.md
PHOLD_EVENT_QUEUE -- requirements
Module: phold_event_queue

Interface
REQ-001 Parameter NIDB, default 3, sets the bits in LP ID; 2^NIDB LPs are seeded at reset.
REQ-002 Parameter NQB, default 4, sets the bits in queue index; depth = 2^NQB, and NQB SHALL be > NIDB.
REQ-003 Parameter NRB, default 8, sets the random word width and SHALL equal 8.
REQ-004 Parameter END_TIME, default 16'd1000; events with time >= END_TIME are retired, not queued.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  core done/ready level (high = core idle, result valid).
REQ-008 in_time  in  16  core-generated event time.
REQ-009 in_target  in  NIDB  core-generated target LP.
REQ-010 inj_valid  in  1  external injection request.
REQ-011 inj_time / inj_id  in  16 / NIDB  injected event.
REQ-012 inj_ready  out  1  injection accepted this cycle when inj_valid && inj_ready.
REQ-013 event_valid  out  1  one-cycle dispatch strobe to core.
REQ-014 event_id / event_time  out  NIDB / 16  dispatched event, held until next dispatch.
REQ-015 global_time  out  16  registered GVT.
REQ-016 random_out  out  NRB  LFSR word, stable in event_valid cycle.
REQ-017 count  out  NQB+1  valid queue entries.
REQ-018 done  out  1  simulation complete.
REQ-019 overflow  out  1  sticky: core event dropped on full queue.

Function
REQ-020 The queue SHALL hold 2^NQB entries {valid, time[15:0], id}; inserts go to the lowest-index free slot.
REQ-021 Min-select SHALL pick the valid entry with smallest unsigned time, ties to lowest index.
REQ-022 FSM states are IDLE, SEND, WAIT_ACK, and WAIT_DONE.
REQ-023 IDLE with count>0 SHALL latch the min entry into event_id/event_time, clear its valid bit, advance the LFSR, and go to SEND next cycle.
REQ-024 IDLE with count==0 SHALL remain in IDLE.
REQ-025 SEND SHALL assert event_valid for exactly one cycle, then go to WAIT_ACK.
REQ-026 WAIT_ACK SHALL wait for in_valid==0, then go to WAIT_DONE.
REQ-027 WAIT_DONE SHALL wait for in_valid==1; in that cycle it captures in_time/in_target and goes to IDLE.
REQ-028 On WAIT_DONE capture, in_time < END_TIME SHALL insert {in_time, in_target}; otherwise the event is discarded.
REQ-029 A core insert with the queue full SHALL drop the event and set overflow, which holds until rst.
REQ-030 inj_ready = !full && !(core insert this cycle); a core insert has priority over injection.
REQ-031 An accepted injection SHALL insert the entry unconditionally, with no END_TIME filter.
REQ-032 count SHALL reflect insert and remove from the same cycle; a simultaneous remove and insert leaves count unchanged.
REQ-033 global_time SHALL be registered each cycle as the min of valid queue times and event_time when not in IDLE; it holds its value when the queue is empty and the FSM is in IDLE.
REQ-034 The LFSR SHALL be an 8-bit Fibonacci shift-left with feedback r[7]^r[5]^r[4]^r[3]; it advances only on dispatch and never reaches 0.
REQ-035 done SHALL be set when the FSM is in IDLE, count==0, and inj_valid==0; it clears on any later insert.
REQ-036 Times SHALL be unsigned 16-bit; wrap-around is not corrected.

Reset
REQ-037 rst SHALL force the FSM to IDLE, event_valid=0, event_id=0, event_time=0, global_time=0, random_out=8'hA5, done=0, overflow=0, and inj_ready=0 during reset.
REQ-038 rst SHALL seed slots 0..2^NIDB-1 with {valid=1, time=0, id=slot} and all other slots invalid; count=2^NIDB.
REQ-039 rst asserted mid-operation SHALL abandon the in-flight event and any capture in progress; the next dispatch comes from the reseeded queue.

Verification
REQ-040 Release rst -> event_valid pulses exactly one cycle, 2 cycles after release, with id=0, time=0, and count=7.
REQ-041 After dispatch, drive in_valid 0 then 1 with in_time=25, in_target=3 -> slot 0={25,3}, count=8, and the next dispatch is id=1, time=0.
REQ-042 Run until the only remaining entry has time 25 -> it is dispatched; in_time=1000 -> discarded, count=0, done=1, and no further event_valid.
REQ-043 Dispatch once (count=7), inject 9 events (count=16, inj_ready=0), then complete with in_time=40 -> overflow=1 and count stays 16.
REQ-044 inj_valid high in the same cycle as a WAIT_DONE capture -> inj_ready=0 that cycle; the injection is accepted the next cycle with count +1.
REQ-045 Assert rst while in WAIT_DONE -> all outputs return to reset values, count=8, and random_out=8'hA5.
